muu_response_combine512: RTL and testbench

MUU_RESPONSE_COMBINE512 -- requirements
Module: muu_response_combine512

---
 rtl/muu_response_combine512.sv | 199 +++++++++++++++++++
 tb/tb_muu_response_combine512.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/muu_response_combine512.sv
// Merges a metadata header, key words and value words into one output packet stream.
// Every output word passes through a single holding register that is stable while stalled.
module muu_response_combine512 #(
  parameter int NET_META_WIDTH = 64,
  parameter int VALUE_WIDTH    = 512,
  parameter int USER_BITS      = 3,
  parameter int OPS_META_WIDTH = 96,
  localparam int MW            = NET_META_WIDTH + OPS_META_WIDTH + USER_BITS,
  localparam int DW            = NET_META_WIDTH + VALUE_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [MW-1:0]          meta_data,
  input  logic                   meta_valid,
  output logic                   meta_ready,
  input  logic [63:0]            key_data,
  input  logic                   key_valid,
  input  logic                   key_last,
  output logic                   key_ready,
  input  logic [VALUE_WIDTH-1:0] value_data,
  input  logic                   value_valid,
  input  logic                   value_last,
  output logic                   value_ready,
  output logic [DW-1:0]          m_axis_tdata,
  output logic                   m_axis_tvalid,
  output logic                   m_axis_tlast,
  output logic [USER_BITS-1:0]   m_axis_tuserid,
  input  logic                   m_axis_tready,
  output logic [15:0]            err_count
);

  localparam int NMW     = NET_META_WIDTH;
  localparam int UID_LSB = NET_META_WIDTH + OPS_META_WIDTH;

  typedef enum logic [2:0] {S_IDLE, S_HDR2, S_KEY, S_VALUE, S_VDRAIN} state_t;

  state_t                 state_q, state_d;
  logic [NMW-1:0]         net_q, net_d;
  logic [15:0]            loadlen_q, loadlen_d;
  logic [7:0]             opcode_q, opcode_d;
  logic [7:0]             peer_q, peer_d;
  logic [23:0]            hdr_q, hdr_d;
  logic [7:0]             keyleft_q, keyleft_d;
  logic [12:0]            valleft_q, valleft_d;
  logic [USER_BITS-1:0]   uid_q, uid_d;
  logic [DW-1:0]          tdata_q, tdata_d;
  logic                   tvalid_q, tvalid_d;
  logic                   tlast_q, tlast_d;
  logic [USER_BITS-1:0]   tuser_q, tuser_d;
  logic [15:0]            err_q, err_d;
  logic                   err_inc;
  logic                   rst_q;

  // Field views of the incoming metadata word.
  logic [NMW-1:0]         m_net;
  logic [12:0]            m_vw;
  logic [7:0]             m_keylen, m_peer, m_opcode;
  logic [31:0]            m_hdr;
  logic [USER_BITS-1:0]   m_uid;
  logic [15:0]            m_loadlen;
  logic                   unused_meta;

  assign m_net       = meta_data[NMW-1:0];
  assign m_vw        = meta_data[NMW+15:NMW+3];
  assign m_keylen    = meta_data[NMW+23:NMW+16];
  assign m_peer      = meta_data[NMW+31:NMW+24];
  assign m_hdr       = meta_data[NMW+63:NMW+32];
  assign m_opcode    = meta_data[NMW+87:NMW+80];
  assign m_uid       = meta_data[MW-1:UID_LSB];
  assign m_loadlen   = {8'b0, m_keylen} + {3'b0, m_vw};
  assign unused_meta = ^{meta_data[NMW+2:NMW], m_hdr[31:24],
                         meta_data[NMW+79:NMW+64], meta_data[UID_LSB-1:NMW+88]};

  logic [VALUE_WIDTH-1:0] w0_pay, w1_pay, key_pay;
  assign w0_pay  = {{(VALUE_WIDTH-48){1'b0}}, m_loadlen, m_opcode, m_peer, m_hdr[15:0]};
  assign w1_pay  = {{(VALUE_WIDTH-48){1'b0}}, loadlen_q, opcode_q, hdr_q};
  assign key_pay = {{(VALUE_WIDTH-64){1'b0}}, key_data};

  logic outfree, meta_fire, key_fire, value_fire;
  assign outfree     = ~tvalid_q | m_axis_tready;
  // rst_q holds the readies low for the cycle after any reset edge.
  assign meta_ready  = (state_q == S_IDLE) & outfree & ~rst_q;
  assign key_ready   = (state_q == S_KEY) & outfree & ~rst_q;
  assign value_ready = (((state_q == S_VALUE) & outfree) | (state_q == S_VDRAIN)) & ~rst_q;
  assign meta_fire   = meta_valid & meta_ready;
  assign key_fire    = key_valid & key_ready;
  assign value_fire  = value_valid & value_ready;

  always_comb begin
    state_d   = state_q;
    net_d     = net_q;
    loadlen_d = loadlen_q;
    opcode_d  = opcode_q;
    peer_d    = peer_q;
    hdr_d     = hdr_q;
    keyleft_d = keyleft_q;
    valleft_d = valleft_q;
    uid_d     = uid_q;
    tdata_d   = tdata_q;
    tuser_d   = tuser_q;
    tvalid_d  = outfree ? 1'b0 : tvalid_q;
    tlast_d   = outfree ? 1'b0 : tlast_q;
    err_inc   = 1'b0;
    case (state_q)
      S_IDLE: if (meta_fire) begin
        net_d     = m_net;
        loadlen_d = m_loadlen;
        opcode_d  = m_opcode;
        peer_d    = m_peer;
        hdr_d     = m_hdr[23:0];
        keyleft_d = m_keylen;
        valleft_d = m_vw;
        uid_d     = m_uid;
        tdata_d   = {m_net, w0_pay};
        tuser_d   = m_uid;
        tvalid_d  = 1'b1;
        state_d   = S_HDR2;
      end
      S_HDR2: if (outfree) begin
        tdata_d  = {net_q, w1_pay};
        tuser_d  = uid_q;
        tvalid_d = 1'b1;
        tlast_d  = (loadlen_q == 16'd0);
        if (loadlen_q == 16'd0)    state_d = S_IDLE;
        else if (keyleft_q != 8'd0) state_d = S_KEY;
        else                        state_d = S_VALUE;
      end
      S_KEY: if (key_fire) begin
        tdata_d   = {net_q, key_pay};
        tuser_d   = uid_q;
        tvalid_d  = 1'b1;
        keyleft_d = keyleft_q - 8'd1;
        err_inc   = key_last != (keyleft_q == 8'd1);
        if (keyleft_q == 8'd1) begin
          if (valleft_q == 13'd0) begin
            tlast_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_VALUE;
          end
        end
      end
      S_VALUE: if (value_fire) begin
        tdata_d   = {net_q, value_data};
        tuser_d   = uid_q;
        tvalid_d  = 1'b1;
        valleft_d = valleft_q - 13'd1;
        if (valleft_q == 13'd1) begin
          tlast_d = 1'b1;
          err_inc = ~value_last;
          state_d = value_last ? S_IDLE : S_VDRAIN;
        end else if (value_last) begin
          tlast_d = 1'b1;
          err_inc = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_VDRAIN: if (value_fire && value_last) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    err_d = (err_inc && err_q != 16'hFFFF) ? err_q + 16'd1 : err_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      err_q    <= 16'd0;
      rst_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      err_q    <= err_d;
      rst_q    <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    net_q     <= net_d;
    loadlen_q <= loadlen_d;
    opcode_q  <= opcode_d;
    peer_q    <= peer_d;
    hdr_q     <= hdr_d;
    keyleft_q <= keyleft_d;
    valleft_q <= valleft_d;
    uid_q     <= uid_d;
    tdata_q   <= tdata_d;
    tuser_q   <= tuser_d;
  end

  assign m_axis_tdata   = tdata_q;
  assign m_axis_tvalid  = tvalid_q;
  assign m_axis_tlast   = tlast_q;
  assign m_axis_tuserid = tuser_q;
  assign err_count      = err_q;

endmodule

// File: tb/tb_muu_response_combine512.sv
// Directed bench for muu_response_combine512: packets are collected at the output
// and compared word-by-word against expectations built from the header fields.
module tb_muu_response_combine512;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [162:0] meta_data = '0;
  logic         meta_valid = 1'b0;
  logic         meta_ready;
  logic [63:0]  key_data = '0;
  logic         key_valid = 1'b0, key_last = 1'b0, key_ready;
  logic [511:0] value_data = '0;
  logic         value_valid = 1'b0, value_last = 1'b0, value_ready;
  logic [575:0] m_axis_tdata;
  logic         m_axis_tvalid, m_axis_tlast;
  logic [2:0]   m_axis_tuserid;
  logic         m_axis_tready = 1'b1;
  logic [15:0]  err_count;

  muu_response_combine512 dut (
    .clk(clk), .rst(rst),
    .meta_data(meta_data), .meta_valid(meta_valid), .meta_ready(meta_ready),
    .key_data(key_data), .key_valid(key_valid), .key_last(key_last), .key_ready(key_ready),
    .value_data(value_data), .value_valid(value_valid), .value_last(value_last),
    .value_ready(value_ready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
    .m_axis_tuserid(m_axis_tuserid), .m_axis_tready(m_axis_tready), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  logic [575:0] got_d[$];
  logic         got_l[$];
  logic [2:0]   got_u[$];
  logic [575:0] exp_d[$];
  logic         exp_l[$];

  logic         tog_en = 1'b0;
  logic         rdy_seen = 1'b0;
  logic         stall_f = 1'b0;
  logic [576:0] held = '0;
  int           hold_err = 0;

  always @(posedge clk) begin
    if (!rst && m_axis_tvalid && m_axis_tready) begin
      got_d.push_back(m_axis_tdata);
      got_l.push_back(m_axis_tlast);
      got_u.push_back(m_axis_tuserid);
    end
    if (key_ready || value_ready) rdy_seen <= 1'b1;
  end

  always @(posedge clk) begin
    if (rst) begin
      stall_f <= 1'b0;
    end else begin
      if (stall_f && (!m_axis_tvalid || {m_axis_tlast, m_axis_tdata} !== held))
        hold_err <= hold_err + 1;
      stall_f <= m_axis_tvalid && !m_axis_tready;
      held    <= {m_axis_tlast, m_axis_tdata};
    end
  end

  always @(posedge clk) begin
    #1;
    m_axis_tready = tog_en ? ~m_axis_tready : 1'b1;
  end

  task automatic chk(input string tag, input logic [575:0] obs, input logic [575:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [162:0] mk_meta(input logic [63:0] net, input logic [15:0] vl8,
                                           input logic [7:0] kl, input logic [7:0] peer,
                                           input logic [31:0] hdr, input logic [7:0] op,
                                           input logic [2:0] uid);
    return {uid, 8'hA5, op, 16'hBEEF, hdr, peer, kl, vl8, net};
  endfunction

  function automatic logic [511:0] vpat(input logic [31:0] n);
    return {16{n ^ 32'h5A5A_0000}};
  endfunction

  task automatic push_hdr(input logic [63:0] net, input logic [15:0] ll, input logic [7:0] op,
                          input logic [7:0] peer, input logic [31:0] hdr, input logic last1);
    exp_d.push_back({net, 448'b0, 16'b0, ll, op, peer, hdr[15:0]});
    exp_l.push_back(1'b0);
    exp_d.push_back({net, 464'b0, ll, op, hdr[23:0]});
    exp_l.push_back(last1);
  endtask

  task automatic push_word(input logic [63:0] net, input logic [511:0] pay, input logic last);
    exp_d.push_back({net, pay});
    exp_l.push_back(last);
  endtask

  task automatic send_meta(input logic [162:0] m);
    int n = 0;
    meta_data = m; meta_valid = 1'b1;
    do begin @(negedge clk); n++; end while (!meta_ready && n < 200);
    if (!meta_ready) chk("meta_timeout", 576'(meta_ready), 576'd1);
    @(posedge clk); #1;
    meta_valid = 1'b0;
  endtask

  task automatic send_key(input logic [63:0] k, input logic last);
    int n = 0;
    key_data = k; key_last = last; key_valid = 1'b1;
    do begin @(negedge clk); n++; end while (!key_ready && n < 200);
    if (!key_ready) chk("key_timeout", 576'(key_ready), 576'd1);
    @(posedge clk); #1;
    key_valid = 1'b0; key_last = 1'b0;
  endtask

  task automatic send_value(input logic [511:0] v, input logic last);
    int n = 0;
    value_data = v; value_last = last; value_valid = 1'b1;
    do begin @(negedge clk); n++; end while (!value_ready && n < 200);
    if (!value_ready) chk("value_timeout", 576'(value_ready), 576'd1);
    @(posedge clk); #1;
    value_valid = 1'b0; value_last = 1'b0;
  endtask

  task automatic wait_words(input int n);
    for (int i = 0; i < 200 && got_d.size() < n; i++) @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic check_pkt(input string tag, input logic [2:0] uid);
    chk({tag, "_count"}, 576'(got_d.size()), 576'(exp_d.size()));
    for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
      chk($sformatf("%s_w%0d_data", tag, i), got_d[i], exp_d[i]);
      chk($sformatf("%s_w%0d_last", tag, i), 576'(got_l[i]), 576'(exp_l[i]));
      chk($sformatf("%s_w%0d_uid", tag, i), 576'(got_u[i]), 576'(uid));
    end
    got_d.delete(); got_l.delete(); got_u.delete();
    exp_d.delete(); exp_l.delete();
  endtask

  localparam logic [63:0] NET_A = 64'h1111_2222_3333_4444;
  localparam logic [63:0] NET_B = 64'hCAFE_F00D_0123_4567;
  localparam logic [31:0] HDR_A = 32'hDEAD_BEEF;
  localparam logic [31:0] HDR_B = 32'h7654_3210;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid", 576'(m_axis_tvalid), 576'd0);
    chk("rst_tlast", 576'(m_axis_tlast), 576'd0);
    chk("rst_err", 576'(err_count), 576'd0);
    chk("rst_readies", 576'({meta_ready, key_ready, value_ready}), 576'd0);
    rst = 1'b0;

    // Nominal packet: one key word, two value words.
    send_meta(mk_meta(NET_A, 16'd16, 8'd1, 8'h07, HDR_A, 8'h21, 3'd5));
    send_key(64'h0102_0304_0506_0708, 1'b1);
    send_value(vpat(32'd1), 1'b0);
    send_value(vpat(32'd2), 1'b1);
    push_hdr(NET_A, 16'd3, 8'h21, 8'h07, HDR_A, 1'b0);
    push_word(NET_A, {448'b0, 64'h0102_0304_0506_0708}, 1'b0);
    push_word(NET_A, vpat(32'd1), 1'b0);
    push_word(NET_A, vpat(32'd2), 1'b1);
    wait_words(5);
    check_pkt("nominal", 3'd5);
    chk("nominal_err", 576'(err_count), 576'd0);

    // Header-only packet.
    rdy_seen = 1'b0;
    send_meta(mk_meta(NET_B, 16'd0, 8'd0, 8'h33, HDR_B, 8'h44, 3'd2));
    push_hdr(NET_B, 16'd0, 8'h44, 8'h33, HDR_B, 1'b1);
    wait_words(2);
    check_pkt("hdronly", 3'd2);
    chk("hdronly_no_kv_ready", 576'(rdy_seen), 576'd0);

    // Backpressure: tready toggling every cycle.
    tog_en = 1'b1;
    send_meta(mk_meta(NET_B, 16'd24, 8'd1, 8'h09, HDR_A, 8'h55, 3'd7));
    send_key(64'hAAAA_BBBB_CCCC_DDDD, 1'b1);
    send_value(vpat(32'd10), 1'b0);
    send_value(vpat(32'd11), 1'b0);
    send_value(vpat(32'd12), 1'b1);
    push_hdr(NET_B, 16'd4, 8'h55, 8'h09, HDR_A, 1'b0);
    push_word(NET_B, {448'b0, 64'hAAAA_BBBB_CCCC_DDDD}, 1'b0);
    push_word(NET_B, vpat(32'd10), 1'b0);
    push_word(NET_B, vpat(32'd11), 1'b0);
    push_word(NET_B, vpat(32'd12), 1'b1);
    wait_words(6);
    tog_en = 1'b0;
    check_pkt("stall", 3'd7);
    chk("stall_hold", 576'(hold_err), 576'd0);

    // Early value_last on the 2nd of 3 value words.
    send_meta(mk_meta(NET_A, 16'd24, 8'd0, 8'h01, HDR_B, 8'h66, 3'd1));
    send_value(vpat(32'd20), 1'b0);
    send_value(vpat(32'd21), 1'b1);
    push_hdr(NET_A, 16'd3, 8'h66, 8'h01, HDR_B, 1'b0);
    push_word(NET_A, vpat(32'd20), 1'b0);
    push_word(NET_A, vpat(32'd21), 1'b1);
    wait_words(4);
    check_pkt("early", 3'd1);
    chk("early_err", 576'(err_count), 576'd1);

    send_meta(mk_meta(NET_B, 16'd8, 8'd0, 8'h02, HDR_A, 8'h77, 3'd3));
    send_value(vpat(32'd30), 1'b1);
    push_hdr(NET_B, 16'd1, 8'h77, 8'h02, HDR_A, 1'b0);
    push_word(NET_B, vpat(32'd30), 1'b1);
    wait_words(3);
    check_pkt("after_early", 3'd3);
    chk("after_early_err", 576'(err_count), 576'd1);

    // Late value_last: two extra upstream words are drained.
    send_meta(mk_meta(NET_A, 16'd8, 8'd0, 8'h04, HDR_A, 8'h88, 3'd4));
    send_value(vpat(32'd40), 1'b0);
    send_value(vpat(32'd41), 1'b0);
    send_value(vpat(32'd42), 1'b1);
    push_hdr(NET_A, 16'd1, 8'h88, 8'h04, HDR_A, 1'b0);
    push_word(NET_A, vpat(32'd40), 1'b1);
    wait_words(3);
    check_pkt("drain", 3'd4);
    chk("drain_err", 576'(err_count), 576'd2);

    // Two key words with key_last on the wrong word both times.
    send_meta(mk_meta(NET_B, 16'd0, 8'd2, 8'h05, HDR_B, 8'h99, 3'd6));
    send_key(64'h1, 1'b1);
    send_key(64'h2, 1'b0);
    push_hdr(NET_B, 16'd2, 8'h99, 8'h05, HDR_B, 1'b0);
    push_word(NET_B, {448'b0, 64'h1}, 1'b0);
    push_word(NET_B, {448'b0, 64'h2}, 1'b1);
    wait_words(4);
    check_pkt("keyerr", 3'd6);
    chk("keyerr_err", 576'(err_count), 576'd4);

    // Reset while in VALUE abandons the packet.
    send_meta(mk_meta(NET_A, 16'd16, 8'd0, 8'h0A, HDR_A, 8'hAB, 3'd2));
    send_value(vpat(32'd50), 1'b0);
    wait_words(3);
    chk("prerst_count", 576'(got_d.size()), 576'd3);
    chk("prerst_nolast", 576'({got_l[0], got_l[1], got_l[2]}), 576'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_tvalid", 576'(m_axis_tvalid), 576'd0);
    chk("midrst_err", 576'(err_count), 576'd0);
    chk("midrst_readies", 576'({meta_ready, key_ready, value_ready}), 576'd0);
    rst = 1'b0;
    got_d.delete(); got_l.delete(); got_u.delete();
    send_meta(mk_meta(NET_B, 16'd8, 8'd1, 8'h0B, HDR_B, 8'hCD, 3'd0));
    send_key(64'hFEED, 1'b1);
    send_value(vpat(32'd60), 1'b1);
    push_hdr(NET_B, 16'd2, 8'hCD, 8'h0B, HDR_B, 1'b0);
    push_word(NET_B, {448'b0, 64'hFEED}, 1'b0);
    push_word(NET_B, vpat(32'd60), 1'b1);
    wait_words(4);
    check_pkt("postrst", 3'd0);
    chk("postrst_err", 576'(err_count), 576'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
